// File: rtl/hsv_core_dmem_arbiter.sv
// hsv_core_dmem_arbiter: shares one AXI-lite dmem master between two requesters, independent read/write arbitration.
// Optional build macro HSV_DMEM_ARB_FIXED_PRIO_EN: requester 0 always wins contention, no round-robin pointer.
module hsv_core_dmem_arbiter_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic id_i,
  output logic head_o,
  output logic empty_o,
  output logic full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q;
  assign head_o  = mem_q[rp_q];
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) mem_q[wp_q] <= id_i;
      wp_q  <= wp_q + AW'(push_i);
      rp_q  <= rp_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
endmodule

module hsv_core_dmem_arbiter #(
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk_core,
  input  logic             rst_core,
  input  logic [1:0]       req_ar_valid,
  output logic [1:0]       req_ar_ready,
  input  logic [1:0][31:0] req_ar_addr,
  output logic [1:0]       req_r_valid,
  input  logic [1:0]       req_r_ready,
  output logic [31:0]      req_r_data,
  output logic [1:0]       req_r_resp,
  input  logic [1:0]       req_w_valid,
  output logic [1:0]       req_w_ready,
  input  logic [1:0][31:0] req_w_addr,
  input  logic [1:0][31:0] req_w_data,
  input  logic [1:0][3:0]  req_w_strb,
  output logic [1:0]       req_b_valid,
  input  logic [1:0]       req_b_ready,
  output logic [1:0]       req_b_resp,
  output logic             dmem_ar_valid,
  input  logic             dmem_ar_ready,
  output logic [31:0]      dmem_ar_addr,
  input  logic             dmem_r_valid,
  output logic             dmem_r_ready,
  input  logic [31:0]      dmem_r_data,
  input  logic [1:0]       dmem_r_resp,
  output logic             dmem_aw_valid,
  input  logic             dmem_aw_ready,
  output logic [31:0]      dmem_aw_addr,
  output logic             dmem_w_valid,
  input  logic             dmem_w_ready,
  output logic [31:0]      dmem_w_data,
  output logic [3:0]       dmem_w_strb,
  input  logic             dmem_b_valid,
  output logic             dmem_b_ready,
  input  logic [1:0]       dmem_b_resp
);
  logic        ar_held_q, ar_held_d, ar_gnt_q, ar_pick, ar_grant, ar_hs;
  logic        w_held_q, w_held_d, w_gnt_q, w_pick, w_grant, w_fire, aw_hs, w_hs;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [31:0] ar_addr_q, aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic        rf_head, rf_empty, rf_full, r_pop;
  logic        bf_head, bf_empty, bf_full, b_pop;
`ifdef HSV_DMEM_ARB_FIXED_PRIO_EN
  assign ar_pick = ~req_ar_valid[0];
  assign w_pick  = ~req_w_valid[0];
`else
  logic ar_rr_q, w_rr_q;
  assign ar_pick = &req_ar_valid ? ar_rr_q : req_ar_valid[1];
  assign w_pick  = &req_w_valid ? w_rr_q : req_w_valid[1];
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      ar_rr_q <= 1'b0;
      w_rr_q  <= 1'b0;
    end else begin
      if (ar_hs) ar_rr_q <= ~ar_gnt_q;
      if (w_fire) w_rr_q <= ~w_gnt_q;
    end
  end
`endif
  assign ar_grant      = ~ar_held_q & ~rf_full & |req_ar_valid;
  assign ar_hs         = ar_held_q & dmem_ar_ready;
  assign ar_held_d     = ar_grant | (ar_held_q & ~ar_hs);
  assign dmem_ar_valid = ar_held_q;
  assign dmem_ar_addr  = ar_addr_q;
  assign req_ar_ready  = ar_hs ? 2'b01 << ar_gnt_q : 2'b00;
  assign w_grant       = ~w_held_q & ~bf_full & |req_w_valid;
  assign dmem_aw_valid = w_held_q & ~aw_done_q;
  assign dmem_w_valid  = w_held_q & ~w_done_q;
  assign aw_hs         = dmem_aw_valid & dmem_aw_ready;
  assign w_hs          = dmem_w_valid & dmem_w_ready;
  // Write request completes only once both AW and W have handshaken, in either order.
  assign w_fire        = w_held_q & (aw_done_q | aw_hs) & (w_done_q | w_hs);
  assign w_held_d      = w_grant | (w_held_q & ~w_fire);
  assign aw_done_d     = w_held_q & ~w_fire & (aw_done_q | aw_hs);
  assign w_done_d      = w_held_q & ~w_fire & (w_done_q | w_hs);
  assign dmem_aw_addr  = aw_addr_q;
  assign dmem_w_data   = w_data_q;
  assign dmem_w_strb   = w_strb_q;
  assign req_w_ready   = w_fire ? 2'b01 << w_gnt_q : 2'b00;
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      ar_held_q <= 1'b0;
      ar_gnt_q  <= 1'b0;
      ar_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_gnt_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      ar_held_q <= ar_held_d;
      w_held_q  <= w_held_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (ar_grant) begin
        ar_gnt_q  <= ar_pick;
        ar_addr_q <= req_ar_addr[ar_pick];
      end
      if (w_grant) begin
        w_gnt_q   <= w_pick;
        aw_addr_q <= req_w_addr[w_pick];
        w_data_q  <= req_w_data[w_pick];
        w_strb_q  <= req_w_strb[w_pick];
      end
    end
  end
  hsv_core_dmem_arbiter_fifo #(.DEPTH(OUT_DEPTH)) u_rfifo (
    .clk(clk_core), .rst(rst_core), .push_i(ar_hs), .pop_i(r_pop), .id_i(ar_gnt_q),
    .head_o(rf_head), .empty_o(rf_empty), .full_o(rf_full)
  );
  hsv_core_dmem_arbiter_fifo #(.DEPTH(OUT_DEPTH)) u_bfifo (
    .clk(clk_core), .rst(rst_core), .push_i(w_fire), .pop_i(b_pop), .id_i(w_gnt_q),
    .head_o(bf_head), .empty_o(bf_empty), .full_o(bf_full)
  );
  // An orphan response (empty owner FIFO) is never acknowledged.
  assign dmem_r_ready = ~rf_empty & req_r_ready[rf_head];
  assign req_r_valid  = (~rf_empty & dmem_r_valid) ? 2'b01 << rf_head : 2'b00;
  assign req_r_data   = dmem_r_data;
  assign req_r_resp   = dmem_r_resp;
  assign r_pop        = dmem_r_valid & dmem_r_ready;
  assign dmem_b_ready = ~bf_empty & req_b_ready[bf_head];
  assign req_b_valid  = (~bf_empty & dmem_b_valid) ? 2'b01 << bf_head : 2'b00;
  assign req_b_resp   = dmem_b_resp;
  assign b_pop        = dmem_b_valid & dmem_b_ready;
  a_r_owner: assert property (@(posedge clk_core) disable iff (rst_core) dmem_r_valid |-> ~rf_empty);
  a_b_owner: assert property (@(posedge clk_core) disable iff (rst_core) dmem_b_valid |-> ~bf_empty);
endmodule

// File: tb/tb_hsv_core_dmem_arbiter.sv
// tb_hsv_core_dmem_arbiter: directed vector table plus hand sequences for hsv_core_dmem_arbiter.
module tb_hsv_core_dmem_arbiter;
  logic clk_core = 1'b0;
  logic rst_core;
  logic [1:0] req_ar_valid, req_ar_ready, req_r_valid, req_r_ready, req_r_resp;
  logic [1:0][31:0] req_ar_addr, req_w_addr, req_w_data;
  logic [31:0] req_r_data, dmem_ar_addr, dmem_r_data, dmem_aw_addr, dmem_w_data;
  logic [1:0] req_w_valid, req_w_ready, req_b_valid, req_b_ready, req_b_resp, dmem_r_resp, dmem_b_resp;
  logic [1:0][3:0] req_w_strb;
  logic [3:0] dmem_w_strb;
  logic dmem_ar_valid, dmem_ar_ready, dmem_r_valid, dmem_r_ready;
  logic dmem_aw_valid, dmem_aw_ready, dmem_w_valid, dmem_w_ready, dmem_b_valid, dmem_b_ready;
  int n_vec = 0, n_err = 0;
  typedef struct {
    logic [1:0] arv; logic ardy; logic rv; logic [1:0] rrdy;
    logic e_arv; logic [31:0] e_addr; logic [1:0] e_arr; logic [1:0] e_rv; logic e_rrdy;
  } vec_t;
  vec_t tbl[13];
  logic [1:0] exp_own[4];

  hsv_core_dmem_arbiter #(.OUT_DEPTH(4)) dut (
    .clk_core(clk_core), .rst_core(rst_core),
    .req_ar_valid(req_ar_valid), .req_ar_ready(req_ar_ready), .req_ar_addr(req_ar_addr),
    .req_r_valid(req_r_valid), .req_r_ready(req_r_ready), .req_r_data(req_r_data), .req_r_resp(req_r_resp),
    .req_w_valid(req_w_valid), .req_w_ready(req_w_ready), .req_w_addr(req_w_addr),
    .req_w_data(req_w_data), .req_w_strb(req_w_strb),
    .req_b_valid(req_b_valid), .req_b_ready(req_b_ready), .req_b_resp(req_b_resp),
    .dmem_ar_valid(dmem_ar_valid), .dmem_ar_ready(dmem_ar_ready), .dmem_ar_addr(dmem_ar_addr),
    .dmem_r_valid(dmem_r_valid), .dmem_r_ready(dmem_r_ready), .dmem_r_data(dmem_r_data), .dmem_r_resp(dmem_r_resp),
    .dmem_aw_valid(dmem_aw_valid), .dmem_aw_ready(dmem_aw_ready), .dmem_aw_addr(dmem_aw_addr),
    .dmem_w_valid(dmem_w_valid), .dmem_w_ready(dmem_w_ready), .dmem_w_data(dmem_w_data), .dmem_w_strb(dmem_w_strb),
    .dmem_b_valid(dmem_b_valid), .dmem_b_ready(dmem_b_ready), .dmem_b_resp(dmem_b_resp)
  );

  always #5 clk_core = ~clk_core;

  task automatic tick;
    @(posedge clk_core);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic ar_step(input logic ev, input logic [1:0] er);
    #2;
    chk("ar_valid", 32'(dmem_ar_valid), 32'(ev));
    chk("ar_ready", 32'(req_ar_ready), 32'(er));
    tick;
  endtask

  task automatic do_reset;
    rst_core = 1'b1;
    req_ar_valid = '0; req_r_ready = '0; req_w_valid = '0; req_b_ready = '0;
    dmem_ar_ready = 1'b0; dmem_r_valid = 1'b0; dmem_aw_ready = 1'b0; dmem_w_ready = 1'b0; dmem_b_valid = 1'b0;
    dmem_r_data = '0; dmem_r_resp = '0; dmem_b_resp = '0;
    tick;
    tick;
    rst_core = 1'b0;
  endtask

  initial begin
    req_ar_addr = '0; req_w_addr = '0; req_w_data = '0; req_w_strb = '0;
    tbl[0]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 32'h000, 2'b00, 2'b00, 1'b0};
    tbl[1]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 32'h100, 2'b01, 2'b00, 1'b0};
    tbl[2]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b0, 32'h100, 2'b00, 2'b01, 1'b1};
    tbl[3]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 32'h200, 2'b10, 2'b00, 1'b0};
    tbl[4]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b0, 32'h200, 2'b00, 2'b10, 1'b1};
    tbl[5]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 32'h100, 2'b01, 2'b00, 1'b0};
    tbl[6]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b0, 32'h100, 2'b00, 2'b01, 1'b1};
    tbl[7]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 32'h200, 2'b10, 2'b00, 1'b0};
    tbl[8]  = '{2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 32'h200, 2'b00, 2'b10, 1'b0};
    tbl[9]  = '{2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 32'h100, 2'b01, 2'b10, 1'b1};
    tbl[10] = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b0, 32'h100, 2'b00, 2'b01, 1'b1};
    tbl[11] = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 32'h200, 2'b10, 2'b00, 1'b0};
    tbl[12] = '{2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 32'h200, 2'b00, 2'b10, 1'b1};
    do_reset;
    req_r_ready = 2'b11; req_b_ready = 2'b11;
    #2;
    chk("rst_ar_valid", 32'(dmem_ar_valid), 0);
    chk("rst_aw_valid", 32'(dmem_aw_valid), 0);
    chk("rst_w_valid", 32'(dmem_w_valid), 0);
    chk("rst_ar_ready", 32'(req_ar_ready), 0);
    chk("rst_w_ready", 32'(req_w_ready), 0);
    chk("rst_r_ready", 32'(dmem_r_ready), 0);
    chk("rst_b_ready", 32'(dmem_b_ready), 0);
    chk("rst_r_valid", 32'(req_r_valid), 0);
    chk("rst_b_valid", 32'(req_b_valid), 0);
    tick;
    // round-robin read alternation with in-order response routing
    do_reset;
    req_ar_addr[0] = 32'h100; req_ar_addr[1] = 32'h200;
    for (int i = 0; i < 13; i++) begin
      req_ar_valid = tbl[i].arv; dmem_ar_ready = tbl[i].ardy; dmem_r_valid = tbl[i].rv; req_r_ready = tbl[i].rrdy;
      #2;
      chk("tbl_ar_valid", 32'(dmem_ar_valid), 32'(tbl[i].e_arv));
      chk("tbl_ar_addr", dmem_ar_addr, tbl[i].e_addr);
      chk("tbl_ar_ready", 32'(req_ar_ready), 32'(tbl[i].e_arr));
      chk("tbl_r_valid", 32'(req_r_valid), 32'(tbl[i].e_rv));
      chk("tbl_r_ready", 32'(dmem_r_ready), 32'(tbl[i].e_rrdy));
      tick;
    end
    // owner FIFO full blocks grants; pop+push together keeps the level
    do_reset;
    req_ar_valid = 2'b01; dmem_ar_ready = 1'b1; req_r_ready = 2'b01;
    for (int i = 0; i < 4; i++) begin
      ar_step(1'b0, 2'b00);
      ar_step(1'b1, 2'b01);
    end
    for (int i = 0; i < 3; i++) ar_step(1'b0, 2'b00);
    dmem_r_valid = 1'b1;
    #2;
    chk("full_pop_r_valid", 32'(req_r_valid), 32'h1);
    chk("full_pop_r_ready", 32'(dmem_r_ready), 32'h1);
    ar_step(1'b0, 2'b00);
    dmem_r_valid = 1'b0;
    ar_step(1'b0, 2'b00);
    dmem_r_valid = 1'b1;
    ar_step(1'b1, 2'b01);
    dmem_r_valid = 1'b0;
    ar_step(1'b0, 2'b00);
    ar_step(1'b1, 2'b01);
    for (int i = 0; i < 3; i++) ar_step(1'b0, 2'b00);
    req_ar_valid = 2'b00; dmem_r_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("drain_r_valid", 32'(req_r_valid), 32'h1);
      chk("drain_r_ready", 32'(dmem_r_ready), 32'h1);
      tick;
    end
    dmem_r_valid = 1'b0;
    #2;
    chk("empty_r_ready", 32'(dmem_r_ready), 0);
    tick;
    // write: AW and W handshakes in separate cycles, both orders
    do_reset;
    req_w_addr[0] = 32'h300; req_w_data[0] = 32'hdeadbeef; req_w_strb[0] = 4'hf;
    req_w_addr[1] = 32'h400; req_w_data[1] = 32'h12345678; req_w_strb[1] = 4'h3;
    req_w_valid = 2'b01;
    #2;
    chk("w_pre_aw_valid", 32'(dmem_aw_valid), 0);
    tick;
    dmem_aw_ready = 1'b1;
    #2;
    chk("w_aw_valid", 32'(dmem_aw_valid), 32'h1);
    chk("w_w_valid", 32'(dmem_w_valid), 32'h1);
    chk("w_aw_addr", dmem_aw_addr, 32'h300);
    chk("w_w_data", dmem_w_data, 32'hdeadbeef);
    chk("w_w_strb", 32'(dmem_w_strb), 32'hf);
    chk("w_ready_c1", 32'(req_w_ready), 0);
    tick;
    dmem_aw_ready = 1'b0;
    #2;
    chk("w_aw_dropped", 32'(dmem_aw_valid), 0);
    chk("w_w_held", 32'(dmem_w_valid), 32'h1);
    chk("w_ready_c2", 32'(req_w_ready), 0);
    tick;
    dmem_w_ready = 1'b1;
    #2;
    chk("w_ready_c3", 32'(req_w_ready), 32'h1);
    tick;
    dmem_w_ready = 1'b0; req_w_valid = 2'b00;
    #2;
    chk("w_idle_aw", 32'(dmem_aw_valid), 0);
    chk("w_idle_w", 32'(dmem_w_valid), 0);
    chk("w_ready_c4", 32'(req_w_ready), 0);
    tick;
    req_w_valid = 2'b10;
    tick;
    dmem_w_ready = 1'b1;
    #2;
    chk("w1_aw_addr", dmem_aw_addr, 32'h400);
    chk("w1_w_strb", 32'(dmem_w_strb), 32'h3);
    chk("w1_ready_a", 32'(req_w_ready), 0);
    tick;
    dmem_w_ready = 1'b0; dmem_aw_ready = 1'b1;
    #2;
    chk("w1_w_dropped", 32'(dmem_w_valid), 0);
    chk("w1_aw_held", 32'(dmem_aw_valid), 32'h1);
    chk("w1_ready_b", 32'(req_w_ready), 32'h2);
    tick;
    req_w_valid = 2'b00; dmem_aw_ready = 1'b0;
    dmem_b_valid = 1'b1; dmem_b_resp = 2'b10; req_b_ready = 2'b11;
    #2;
    chk("b0_valid", 32'(req_b_valid), 32'h1);
    chk("b0_ready", 32'(dmem_b_ready), 32'h1);
    chk("b0_resp", 32'(req_b_resp), 32'h2);
    tick;
    dmem_b_resp = 2'b00;
    #2;
    chk("b1_valid", 32'(req_b_valid), 32'h2);
    tick;
    dmem_b_valid = 1'b0;
    #2;
    chk("b_empty_ready", 32'(dmem_b_ready), 0);
    tick;
    // stalled AR keeps grant to requester 1 while requester 0 waits
    do_reset;
    req_ar_addr[0] = 32'h100; req_ar_addr[1] = 32'h200;
    req_ar_valid = 2'b10;
    tick;
    req_ar_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("stall_addr", dmem_ar_addr, 32'h200);
      ar_step(1'b1, 2'b00);
    end
    dmem_ar_ready = 1'b1;
    ar_step(1'b1, 2'b10);
    req_ar_valid = 2'b01;
    ar_step(1'b0, 2'b00);
    #2;
    chk("stall_next_addr", dmem_ar_addr, 32'h100);
    ar_step(1'b1, 2'b01);
    req_ar_valid = 2'b00;
    dmem_r_valid = 1'b1; dmem_r_data = 32'hcafe0001; dmem_r_resp = 2'b01; req_r_ready = 2'b11;
    #2;
    chk("stall_r1_valid", 32'(req_r_valid), 32'h2);
    chk("stall_r1_data", req_r_data, 32'hcafe0001);
    chk("stall_r1_resp", 32'(req_r_resp), 32'h1);
    tick;
    dmem_r_data = 32'hcafe0002;
    #2;
    chk("stall_r0_valid", 32'(req_r_valid), 32'h1);
    chk("stall_r0_data", req_r_data, 32'hcafe0002);
    tick;
    dmem_r_valid = 1'b0;
    // continuous contention
    do_reset;
`ifdef HSV_DMEM_ARB_FIXED_PRIO_EN
    exp_own = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_own = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    req_ar_valid = 2'b11; dmem_ar_ready = 1'b1; req_r_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      ar_step(1'b0, 2'b00);
      ar_step(1'b1, exp_own[i]);
    end
    req_ar_valid = 2'b00; dmem_r_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("contend_r_valid", 32'(req_r_valid), 32'(exp_own[i]));
      tick;
    end
    dmem_r_valid = 1'b0;
    // reset with reads outstanding and a grant held
    do_reset;
    req_ar_valid = 2'b01; dmem_ar_ready = 1'b1; req_r_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      ar_step(1'b0, 2'b00);
      ar_step(1'b1, 2'b01);
    end
    dmem_ar_ready = 1'b0;
    ar_step(1'b0, 2'b00);
    rst_core = 1'b1;
    tick;
    rst_core = 1'b0; req_ar_valid = 2'b00; dmem_ar_ready = 1'b1;
    #2;
    chk("mrst_ar_valid", 32'(dmem_ar_valid), 0);
    chk("mrst_ar_ready", 32'(req_ar_ready), 0);
    chk("mrst_r_ready", 32'(dmem_r_ready), 0);
    tick;
    req_ar_valid = 2'b11;
    ar_step(1'b0, 2'b00);
    ar_step(1'b1, 2'b01);
    req_ar_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      ar_step(1'b0, 2'b00);
      ar_step(1'b1, 2'b01);
    end
    for (int i = 0; i < 2; i++) ar_step(1'b0, 2'b00);
    req_ar_valid = 2'b00; dmem_r_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("mrst_drain", 32'(req_r_valid), 32'h1);
      tick;
    end
    dmem_r_valid = 1'b0;
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
